fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the 8x8 synchronous FIFO (fifo_write, fifo_data_in, fifo_full, fifo_empty, fifo_read) between NUM_REQ producers.
- Round-robin arbitration with a valid/ready style handshake toward the producers.
- A credit counter tracks FIFO occupancy ahead of the FIFO's own flags, so the arbiter never writes to a full FIFO.
- Sits directly in front of the FIFO write side; the consumer drives fifo_read, which the arbiter only observes.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- fifo_depth, 8, FIFO entries; must match the FIFO instance.
- fifo_width, 8, data width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_  in  1  reset, synchronous, active-low.
- arb_en  in  1  1 = grants allowed; 0 = no new grants.
- req  in  NUM_REQ  per-producer valid; held with req_data until granted.
- req_data  in  NUM_REQ*fifo_width  producer i data at bits [i*fifo_width +: fifo_width].
- gnt  out  NUM_REQ  combinational one-hot ready; transfer occurs on req[i] & gnt[i].
- fifo_write  out  1  registered FIFO write strobe.
- fifo_data_in  out  fifo_width  registered FIFO write data.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read  in  1  consumer read strobe (observed only).
- credit  out  $clog2(fifo_depth+1)  free slots not yet committed.
- wr_err  out  1  sticky flag: fifo_write was asserted while fifo_full.

Behaviour:
- Reset (rst_=0 at posedge):
  - fifo_write=0, fifo_data_in=0, credit=fifo_depth, rr_ptr=0, wr_err=0.
  - gnt is forced to 0 while rst_=0.
  - The FIFO shares the same reset, so credits and FIFO contents stay consistent.
  - Reset mid-transfer drops any pending registered write.
- Grant condition: gnt is all-zero unless arb_en=1 and credit>0.
- Grant selection: otherwise gnt is one-hot on the first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- Handshake:
  - Producers must keep req and req_data stable until gnt is seen.
  - gnt never depends on req_data.
  - A producer may hold req high and be granted on consecutive cycles, one word per cycle.
- Write latency: a transfer at cycle T drives fifo_write=1 and fifo_data_in=selected req_data in cycle T+1. With no transfer, fifo_write=0 and fifo_data_in holds its last value.
- rr_ptr update: after a transfer from producer i, rr_ptr = (i+1) mod NUM_REQ. No transfer leaves rr_ptr unchanged.
- Credit accounting (per clock):
  - rd_acc = fifo_read & !fifo_empty.
  - Transfer only: credit-1.
  - rd_acc only: credit+1.
  - Both: unchanged.
  - Neither: unchanged.
- Credit bounds: credit never goes below 0 or above fifo_depth. Grants are blocked at credit=0, so no underflow is possible.
- Credit is conservative: it is decremented at grant, one cycle before the FIFO write lands.
- Invariant: fifo_full=1 implies credit=0.
- Read on empty FIFO: rd_acc=0, credit unchanged.
- Back-to-back operation: with the FIFO empty, credit=8, and one producer streaming, 8 consecutive grants then gnt=0. The next grant comes the cycle after the first accepted read.
- wr_err: set when fifo_write & fifo_full at a posedge; cleared only by reset.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined: adds output gnt_cnt (NUM_REQ*8 bits), per-producer 8-bit counters.
  - Each counter increments on its own transfer and saturates at 255.
  - Counters reset to 0.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Package fifo_arb_pkg:
  - Defaults FIFO_DEPTH_DEF=8, FIFO_WIDTH_DEF=8.
  - Function credit_w(depth)=$clog2(depth+1).
  - Typedef req_idx_t, sized for the maximum NUM_REQ.
- Sub-module fifo_rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant, grant index, any-grant.
- Top level holds credit counter, rr_ptr, output registers, wr_err and stats.

Test Plan:
- Reset: hold rst_=0 for 2 clk with req=4'b1111 -> gnt=0, fifo_write=0, credit=8, wr_err=0.
- Round-robin: req=4'b1111 constant, arb_en=1, no reads -> gnt order 0,1,2,3,0,1,2,3; fifo_write high cycles 1..8 with producer data in the same order; then credit=0 and gnt=0.
- Full stall and release: FIFO full (credit=0, fifo_full=1), req[2]=1 -> no gnt. Pulse fifo_read one cycle -> credit=1, gnt[2] next cycle, write lands following cycle, fifo_full=1 again, wr_err stays 0.
- Simultaneous read and write: credit=3, transfer and accepted read in the same cycle -> credit stays 3.
- Read on empty: fifo_empty=1, fifo_read=1, no req -> credit stays 8, no fifo_write.
- Reset mid-stream: assert rst_=0 in the cycle after a transfer -> fifo_write=0 next cycle, credit=8, rr_ptr=0. First post-reset grant goes to the lowest active requester.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared sizing for the FIFO write-side arbiter: default FIFO geometry,
// credit counter width helper and the producer index type.
package fifo_arb_pkg;

    localparam int FIFO_DEPTH_DEF = 8;
    localparam int FIFO_WIDTH_DEF = 8;
    localparam int MAX_REQ        = 8;
    localparam int REQ_IDX_W      = $clog2(MAX_REQ);

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    // Credit must represent 0..depth inclusive.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// wrapping to the lowest requester when nothing sits above the pointer.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           rr_ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output req_idx_t           gnt_idx,
    output logic               any_gnt
);

    req_idx_t lo_idx;
    req_idx_t hi_idx;
    logic     lo_any;
    logic     hi_any;

    // Descending scan so the last hit is the lowest index in each set.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        lo_any = 1'b0;
        hi_any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = req_idx_t'(i);
                lo_any = 1'b1;
            end
            if (req[i] && (i >= int'(rr_ptr))) begin
                hi_idx = req_idx_t'(i);
                hi_any = 1'b1;
            end
        end
    end

    always_comb begin
        any_gnt = en && lo_any;
        gnt_idx = hi_any ? hi_idx : lo_idx;
        gnt     = '0;
        for (int i = 0; i < NUM_REQ; i++)
            gnt[i] = any_gnt && (gnt_idx == req_idx_t'(i));
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with credit-based flow control. FIFO_WR_ARB_STATS_EN adds per-producer grant counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int fifo_depth = FIFO_DEPTH_DEF,
    parameter int fifo_width = FIFO_WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst_,
    input  logic                              arb_en,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*fifo_width-1:0]     req_data,
    output logic [NUM_REQ-1:0]                gnt,
    output logic                              fifo_write,
    output logic [fifo_width-1:0]             fifo_data_in,
    input  logic                              fifo_full,
    input  logic                              fifo_empty,
    input  logic                              fifo_read,
    output logic [credit_w(fifo_depth)-1:0]   credit,
    output logic                              wr_err
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*8-1:0]              gnt_cnt
`endif
);

    localparam int CW = credit_w(fifo_depth);

    req_idx_t                rr_ptr;
    req_idx_t                gnt_idx;
    logic                    any_gnt;
    logic                    pick_en;
    logic                    xfer;
    logic                    rd_acc;
    logic [fifo_width-1:0]   sel_data;

    // Reset and zero credit both mask the picker, so gnt is 0 in either case.
    assign pick_en = rst_ && arb_en && (credit != '0);

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .en      (pick_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign xfer   = any_gnt;
    assign rd_acc = fifo_read && !fifo_empty;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) sel_data = req_data[i*fifo_width +: fifo_width];
    end

    // Credit drops at grant, a cycle before the write lands, so it never lags the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            fifo_write   <= 1'b0;
            fifo_data_in <= '0;
            credit       <= CW'(fifo_depth);
            rr_ptr       <= '0;
            wr_err       <= 1'b0;
        end else begin
            fifo_write <= xfer;
            if (xfer) begin
                fifo_data_in <= sel_data;
                rr_ptr       <= (gnt_idx == req_idx_t'(NUM_REQ - 1)) ? '0
                                                                      : gnt_idx + req_idx_t'(1);
            end
            if (xfer && !rd_acc)
                credit <= credit - CW'(1);
            else if (!xfer && rd_acc && (credit < CW'(fifo_depth)))
                credit <= credit + CW'(1);
            if (fifo_write && fifo_full)
                wr_err <= 1'b1;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [7:0] cnt_q [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        always_ff @(posedge clk) begin
            if (!rst_)
                cnt_q[g] <= '0;
            else if (req[g] && gnt[g] && (cnt_q[g] != 8'hFF))
                cnt_q[g] <= cnt_q[g] + 8'd1;
        end
        assign gnt_cnt[g*8 +: 8] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a count-only FIFO stand-in, a per-cycle reference
// model with compare process, and directed scenarios pinned by literal checks.
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int D = 8;
    localparam int W = 8;

    logic           clk;
    logic           rst_;
    logic           arb_en;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           fifo_write;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_read;
    logic [3:0]     credit;
    logic           wr_err;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [N*8-1:0] gnt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(.NUM_REQ(N), .fifo_depth(D), .fifo_width(W)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .arb_en       (arb_en),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .fifo_write   (fifo_write),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_read    (fifo_read),
        .credit       (credit),
        .wr_err       (wr_err)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .gnt_cnt      (gnt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO stand-in: occupancy only; full_force fakes a full flag to provoke wr_err.
    int cnt = 0;
    logic full_force;
    always @(posedge clk) begin
        if (!rst_) cnt <= 0;
        else cnt <= cnt + ((fifo_write && cnt < D) ? 1 : 0) - ((fifo_read && cnt > 0) ? 1 : 0);
    end
    assign fifo_full  = full_force || (cnt == D);
    assign fifo_empty = (cnt == 0);

    // Reference model: state after the most recent posedge.
    int         m_credit = D;
    int         m_ptr    = 0;
    bit         m_wr     = 0;
    logic [7:0] m_data   = 0;
    bit         m_err    = 0;

    always @(negedge clk) begin
        logic [N-1:0] eg;
        int sel;
        int idx;
        bit rd_acc;
        eg  = '0;
        sel = 0;
        if (rst_ && arb_en && m_credit > 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (eg == '0 && req[idx]) begin
                    eg[idx] = 1'b1;
                    sel     = idx;
                end
            end
        end
        chk("m_gnt",        32'(gnt),          32'(eg));
        chk("m_fifo_write", 32'(fifo_write),   32'(m_wr));
        chk("m_data",       32'(fifo_data_in), 32'(m_data));
        chk("m_credit",     32'(credit),       32'(m_credit));
        chk("m_wr_err",     32'(wr_err),       32'(m_err));
        if (fifo_full && !full_force) chk("full_zero_credit", 32'(credit), 32'(0));

        if (!rst_) begin
            m_credit = D; m_ptr = 0; m_wr = 0; m_data = 0; m_err = 0;
        end else begin
            if (m_wr && fifo_full) m_err = 1;
            rd_acc = fifo_read && !fifo_empty;
            m_wr   = (eg != '0);
            if (eg != '0) begin
                m_data = req_data[sel*W +: W];
                m_ptr  = (sel + 1) % N;
            end
            m_credit = m_credit - ((eg != '0) ? 1 : 0) + (rd_acc ? 1 : 0);
            if (m_credit > D) m_credit = D;
            if (m_credit < 0) m_credit = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ = 1'b0; arb_en = 1'b1; req = 4'hF; fifo_read = 1'b0; full_force = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'hA0 + 8'(i);

        // Reset held two clocks with all producers requesting.
        tick(); tick();
        #1;
        chk("rst_gnt",     32'(gnt),          32'(0));
        chk("rst_write",   32'(fifo_write),   32'(0));
        chk("rst_credit",  32'(credit),       32'(8));
        chk("rst_wr_err",  32'(wr_err),       32'(0));
        chk("rst_data",    32'(fifo_data_in), 32'(0));
        rst_ = 1'b1;

        // Round-robin burst until credit runs out.
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
            if (k > 0) begin
                chk("rr_write", 32'(fifo_write),   32'(1));
                chk("rr_data",  32'(fifo_data_in), 32'(8'hA0 + (k - 1) % 4));
            end
            tick();
        end
        #1;
        chk("rr_last_data", 32'(fifo_data_in), 32'(8'hA3));
        chk("rr_credit0",   32'(credit),       32'(0));
        chk("rr_gnt_off",   32'(gnt),          32'(0));
        tick();
        #1;
        chk("rr_write_off", 32'(fifo_write),   32'(0));

        // Full stall, then a single read releases one grant.
        req = 4'b0100;
        #1;
        chk("stall_gnt", 32'(gnt), 32'(0));
        tick(); tick();
        #1;
        chk("stall_gnt2", 32'(gnt), 32'(0));
        fifo_read = 1'b1;
        tick();
        fifo_read = 1'b0;
        #1;
        chk("rel_credit", 32'(credit), 32'(1));
        chk("rel_gnt",    32'(gnt),    32'(4'b0100));
        tick();
        req = 4'b0000;
        #1;
        chk("rel_write",  32'(fifo_write),   32'(1));
        chk("rel_data",   32'(fifo_data_in), 32'(8'hA2));
        chk("rel_credit0",32'(credit),       32'(0));
        tick();
        #1;
        chk("rel_wr_err", 32'(wr_err),       32'(0));

        // Drain to credit 3, then transfer and accepted read together.
        fifo_read = 1'b1;
        repeat (3) tick();
        req = 4'b0010;
        #1;
        chk("both_credit_pre", 32'(credit), 32'(3));
        chk("both_gnt",        32'(gnt),    32'(4'b0010));
        tick();
        req = 4'b0000; fifo_read = 1'b0;
        #1;
        chk("both_credit", 32'(credit),       32'(3));
        chk("both_data",   32'(fifo_data_in), 32'(8'hA1));
        tick();

        // Drain completely and keep reading an empty FIFO.
        fifo_read = 1'b1;
        repeat (8) tick();
        #1;
        chk("empty_credit", 32'(credit),     32'(8));
        chk("empty_write",  32'(fifo_write), 32'(0));
        tick();
        #1;
        chk("empty_credit2", 32'(credit), 32'(8));
        fifo_read = 1'b0;

        // Write while the full flag is asserted sets the sticky error.
        full_force = 1'b1;
        req = 4'b0001;
        #1;
        chk("err_gnt", 32'(gnt), 32'(4'b0001));
        tick();
        req = 4'b0000;
        #1;
        chk("err_pre", 32'(wr_err), 32'(0));
        tick();
        full_force = 1'b0;
        #1;
        chk("err_set", 32'(wr_err), 32'(1));
        tick();
        #1;
        chk("err_sticky", 32'(wr_err), 32'(1));

        // Reset right after a transfer drops the pending write and rewinds the pointer.
        req = 4'b0011;
        #1;
        chk("mid_gnt", 32'(gnt), 32'(4'b0010));
        tick();
        rst_ = 1'b0;
        #1;
        chk("mid_gnt_rst", 32'(gnt),        32'(0));
        chk("mid_pending", 32'(fifo_write), 32'(1));
        tick();
        #1;
        chk("mid_write",  32'(fifo_write), 32'(0));
        chk("mid_credit", 32'(credit),     32'(8));
        chk("mid_wr_err", 32'(wr_err),     32'(0));
        rst_ = 1'b1;
        req = 4'b0110;
        #1;
        chk("post_gnt", 32'(gnt), 32'(4'b0010));
        tick();
        req = 4'b0000;
        #1;
        chk("post_data", 32'(fifo_data_in), 32'(8'hA1));
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
